load_register: RTL and testbench



---
 rtl/load_register.sv | 54 +++++
 tb/tb_load_register.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/load_register.sv
// Width-parameterised storage register with a synchronous clear (highest priority) and load enable.
// updated pulses for the cycle after any clear or load edge, even when the stored value is unchanged.
module load_register #(
    parameter int          width       = 32,
    parameter logic [63:0] RESET_VALUE = 64'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [width-1:0] in,
    output logic [width-1:0] out,
    output logic             updated
);

    // Only the low width bits of RESET_VALUE are meaningful.
    localparam logic [width-1:0] RST_VAL = RESET_VALUE[width-1:0];

    logic [width-1:0] data_d;
    logic [width-1:0] data_q;
    logic             updated_d;
    logic             updated_q;

    always_comb begin
        data_d    = data_q;
        updated_d = 1'b0;
        if (clear) begin
            data_d    = RST_VAL;
            updated_d = 1'b1;
        end else if (load) begin
            data_d    = in;
            updated_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q    <= RST_VAL;
            updated_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            updated_q <= updated_d;
        end
    end

    assign out     = data_q;
    assign updated = updated_q;

`ifndef SYNTHESIS
    // Control inputs must be known whenever the register is out of reset.
    ctrl_known_a: assert property (@(posedge clk) disable iff (!reset) !$isunknown({clear, load}));
`endif

endmodule

// File: tb/tb_load_register.sv
// Self-checking bench for load_register: table-driven vectors, hand-written corner sequences,
// and a randomized phase scored against a behavioural model through expected queues.
module tb_load_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        c32, l32, u32;
    logic [31:0] i32, o32;
    logic        c3a, l3a, u3a;
    logic [2:0]  i3a, o3a;
    logic        c3b, l3b, u3b;
    logic [2:0]  i3b, o3b;
    logic        c8, l8, u8;
    logic [7:0]  i8, o8;

    load_register #(.width(32), .RESET_VALUE(64'd0)) dut32 (
        .clk(clk), .reset(reset), .clear(c32), .load(l32), .in(i32), .out(o32), .updated(u32));
    load_register #(.width(3), .RESET_VALUE(64'd0)) dut3a (
        .clk(clk), .reset(reset), .clear(c3a), .load(l3a), .in(i3a), .out(o3a), .updated(u3a));
    load_register #(.width(3), .RESET_VALUE(64'b101)) dut3b (
        .clk(clk), .reset(reset), .clear(c3b), .load(l3b), .in(i3b), .out(o3b), .updated(u3b));
    load_register #(.width(8), .RESET_VALUE(64'h1FF)) dut8 (
        .clk(clk), .reset(reset), .clear(c8), .load(l8), .in(i8), .out(o8), .updated(u8));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          clear;
        bit          load;
        logic [31:0] din;
        logic [31:0] exp_out;
        bit          exp_upd;
    } vec_t;

    vec_t tbl[$];

    logic [32:0] exp_q[$];
    logic [8:0]  exp8_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural rule: clear beats load, any write raises updated, otherwise hold.
    function automatic logic [63:0] model_next(input logic [63:0] cur, input logic [63:0] rv,
                                               input bit clr, input bit ld,
                                               input logic [63:0] din, output bit upd);
        upd = clr || ld;
        if (clr) return rv;
        if (ld)  return din;
        return cur;
    endfunction

    function automatic vec_t mk(input bit clr, input bit ld, input logic [31:0] din,
                                input logic [31:0] eo, input bit eu);
        vec_t v;
        v.clear = clr; v.load = ld; v.din = din; v.exp_out = eo; v.exp_upd = eu;
        return v;
    endfunction

    initial begin
        bit          hb[4];
        logic [2:0]  hs[4];
        logic [2:0]  h;
        logic [63:0] m32, m8;
        bit          mu32, mu8;
        logic [32:0] e;
        logic [8:0]  e8;

        reset = 1'b1;
        c32 = 0; l32 = 0; i32 = '0;
        c3a = 0; l3a = 0; i3a = '0;
        c3b = 0; l3b = 0; i3b = '0;
        c8  = 0; l8  = 0; i8  = '0;

        // Reset asserted between edges takes effect without a clock edge.
        #2 reset = 1'b0;
        #1;
        check("rst_async_o32", o32, 0);
        check("rst_async_o3b", o3b, 3'b101);
        check("rst_trunc_o8", o8, 8'hFF);
        check("rst_async_u8", u8, 0);

        i32 = 32'hDEADBEEF; l32 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_hold_o32", o32, 0);
            check("rst_hold_u32", u32, 0);
        end
        reset = 1'b1;
        tick();
        check("first_load_o32", o32, 32'hDEADBEEF);
        check("first_load_u32", u32, 1);

        tbl.push_back(mk(0, 1, 32'h12345678, 32'h12345678, 1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 32'($urandom), 32'h12345678, 0));
        tbl.push_back(mk(1, 0, 32'hFFFFFFFF, 32'h0, 1));
        tbl.push_back(mk(0, 1, 32'h0, 32'h0, 1));
        tbl.push_back(mk(0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 1));
        tbl.push_back(mk(1, 1, 32'h11111111, 32'h0, 1));
        tbl.push_back(mk(0, 0, 32'h22222222, 32'h0, 0));
        for (int k = 0; k < tbl.size(); k++) begin
            c32 = tbl[k].clear; l32 = tbl[k].load; i32 = tbl[k].din;
            tick();
            check($sformatf("tbl%0d_out", k), o32, tbl[k].exp_out);
            check($sformatf("tbl%0d_upd", k), u32, tbl[k].exp_upd);
        end
        c32 = 0; l32 = 0;

        // Branch-history style shift on the 3-bit register.
        hb = '{1'b1, 1'b0, 1'b1, 1'b1};
        hs = '{3'b001, 3'b010, 3'b101, 3'b011};
        h  = 3'b000;
        for (int k = 0; k < 4; k++) begin
            i3a = {h[1:0], hb[k]};
            l3a = 1'b1;
            tick();
            h = 3'((h * 2 + 3'(hb[k])) % 8);
            check($sformatf("hist%0d_out", k), o3a, hs[k]);
            check($sformatf("hist%0d_upd", k), u3a, 1);
        end

        i3a = 3'b110; l3a = 1'b1;
        i3b = 3'b110; l3b = 1'b1;
        tick();
        check("pre_clr_o3a", o3a, 3'b110);
        check("pre_clr_o3b", o3b, 3'b110);
        c3a = 1'b1; i3a = 3'b111;
        c3b = 1'b1; i3b = 3'b111;
        tick();
        check("clr_prio_o3a", o3a, 3'b000);
        check("clr_prio_u3a", u3a, 1);
        check("clr_prio_o3b", o3b, 3'b101);
        check("clr_prio_u3b", u3b, 1);
        c3a = 0; l3a = 0; c3b = 0; l3b = 0;
        tick();
        check("post_clr_u3b", u3b, 0);
        check("post_clr_o3b", o3b, 3'b101);

        // Mid-cycle reset discards the load pending for the next edge.
        i32 = 32'hA5A5A5A5; l32 = 1'b1;
        tick();
        check("a5_load_o32", o32, 32'hA5A5A5A5);
        i32 = 32'h12345678;
        #2 reset = 1'b0;
        #1;
        check("midcyc_rst_o32", o32, 0);
        check("midcyc_rst_u32", u32, 0);
        tick();
        check("lost_load_o32", o32, 0);
        reset = 1'b1; l32 = 1'b0;
        tick();
        check("after_rst_o32", o32, 0);
        check("after_rst_u32", u32, 0);
        check("after_rst_o8", o8, 8'hFF);

        i8 = 8'h3C; l8 = 1'b1;
        tick();
        check("rep1_o8", o8, 8'h3C);
        check("rep1_u8", u8, 1);
        tick();
        check("rep2_o8", o8, 8'h3C);
        check("rep2_u8", u8, 1);
        l8 = 1'b0;
        tick();
        check("rep3_o8", o8, 8'h3C);
        check("rep3_u8", u8, 0);

        m32 = 64'h0;
        m8  = 64'h3C;
        for (int k = 0; k < 300; k++) begin
            c32 = ($urandom_range(0, 7) == 0);
            l32 = ($urandom_range(0, 1) == 1);
            i32 = 32'($urandom);
            c8  = ($urandom_range(0, 7) == 0);
            l8  = ($urandom_range(0, 1) == 1);
            i8  = 8'($urandom);
            m32 = model_next(m32, 64'h0, c32, l32, {32'h0, i32}, mu32);
            m8  = model_next(m8, 64'hFF, c8, l8, {56'h0, i8}, mu8);
            exp_q.push_back({mu32, m32[31:0]});
            exp8_q.push_back({mu8, m8[7:0]});
            tick();
            e  = exp_q.pop_front();
            e8 = exp8_q.pop_front();
            check($sformatf("rnd%0d_r32", k), {u32, o32}, {31'h0, e});
            check($sformatf("rnd%0d_r8", k), {u8, o8}, {55'h0, e8});
        end
        c32 = 0; l32 = 0; c8 = 0; l8 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
